// File: rtl/nchu_scheduler.sv
// Time-multiplexed leaky integrate-and-fire controller: one datapath walks N virtual neurons per timestep.
// Optional per-neuron refractory counters are enabled by defining NCHU_REFRACT_EN.
module nchu_scheduler #(
  parameter int                 N_NEURONS     = 8,
  parameter logic signed [7:0]  THRESH        = 8'sd2,
  parameter int                 REFRACT_STEPS = 2,
  localparam int                IW            = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_start,
  input  logic [7:0]    mac_data,
  input  logic          mac_valid,
  output logic          mac_ready,
  output logic [IW-1:0] cur_id,
  output logic          spk_valid,
  output logic [IW-1:0] spk_id,
  output logic          busy,
  output logic          step_done,
  input  logic [IW-1:0] dbg_idx,
  output logic [7:0]    dbg_v
);

  localparam int NMEM = 1 << IW;

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_CHECK, S_DONE} state_t;

  state_t             state_q;
  logic [IW-1:0]      idx_q;
  logic signed [7:0]  vtmp_q;
  logic               mac_ready_q;
  logic               spk_valid_q;
  logic               busy_q;
  logic               step_done_q;
  // Sized to the full index space so any dbg_idx value reads a defined entry.
  logic signed [7:0]  mem_q [NMEM];

  logic signed [7:0]  v_cur;
  logic signed [9:0]  v_ext;
  logic signed [9:0]  m_ext;
  logic signed [9:0]  sum_d;
  logic signed [7:0]  vtmp_d;
  logic               fire_d;
  logic               refr_active;

`ifdef NCHU_REFRACT_EN
  logic [3:0] refr_q [NMEM];
  assign refr_active = (refr_q[idx_q] != 4'd0);
`else
  logic unused_refract;
  assign refr_active    = 1'b0;
  assign unused_refract = ^4'(REFRACT_STEPS);
`endif

  // Leak by v/2 + v/4, integrate the input at 10 bits, then clamp to the 8-bit range.
  always_comb begin
    v_cur  = mem_q[idx_q];
    v_ext  = {{2{v_cur[7]}}, v_cur};
    m_ext  = {{2{mac_data[7]}}, mac_data};
    sum_d  = (v_ext >>> 1) + (v_ext >>> 2) + m_ext;
    vtmp_d = sum_d[7:0];
    if (sum_d > 10'sd127) begin
      vtmp_d = 8'sd127;
    end else if (sum_d < -10'sd128) begin
      vtmp_d = -8'sd128;
    end
    fire_d = (vtmp_d >= THRESH) && !refr_active;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      vtmp_q      <= '0;
      mac_ready_q <= 1'b0;
      spk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      for (int i = 0; i < NMEM; i++) begin
        mem_q[i] <= '0;
`ifdef NCHU_REFRACT_EN
        refr_q[i] <= '0;
`endif
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step_start) begin
            state_q     <= S_ACCEPT;
            idx_q       <= '0;
            mac_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_ACCEPT: begin
          if (mac_valid) begin
            state_q     <= S_CHECK;
            vtmp_q      <= vtmp_d;
            mac_ready_q <= 1'b0;
            spk_valid_q <= fire_d;
          end
        end
        S_CHECK: begin
          spk_valid_q <= 1'b0;
`ifdef NCHU_REFRACT_EN
          if (refr_active) begin
            mem_q[idx_q]  <= '0;
            refr_q[idx_q] <= refr_q[idx_q] - 4'd1;
          end else if (spk_valid_q) begin
            mem_q[idx_q]  <= vtmp_q - THRESH;
            refr_q[idx_q] <= 4'(REFRACT_STEPS);
          end else begin
            mem_q[idx_q] <= vtmp_q;
          end
`else
          mem_q[idx_q] <= spk_valid_q ? (vtmp_q - THRESH) : vtmp_q;
`endif
          if (idx_q == IW'(N_NEURONS - 1)) begin
            state_q     <= S_DONE;
            step_done_q <= 1'b1;
          end else begin
            idx_q       <= idx_q + IW'(1);
            state_q     <= S_ACCEPT;
            mac_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          step_done_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mac_ready = mac_ready_q;
  assign spk_valid = spk_valid_q;
  assign busy      = busy_q;
  assign step_done = step_done_q;
  assign cur_id    = idx_q;
  assign spk_id    = idx_q;
  assign dbg_v     = mem_q[dbg_idx];

endmodule

// File: tb/tb_nchu_scheduler.sv
// Scoreboard bench for nchu_scheduler with N=4, THRESH=2: the driver queues expected spikes and
// step_done pulses with their cycle numbers; a negedge monitor pops and compares them.
module tb_nchu_scheduler;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_start = 1'b0;
  logic [7:0] mac_data = 8'd0;
  logic       mac_valid = 1'b0;
  logic [1:0] dbg_idx = 2'd0;
  logic       mac_ready;
  logic [1:0] cur_id;
  logic       spk_valid;
  logic [1:0] spk_id;
  logic       busy;
  logic       step_done;
  logic [7:0] dbg_v;

  nchu_scheduler #(
    .N_NEURONS    (N),
    .THRESH       (8'sd2),
    .REFRACT_STEPS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_start(step_start),
    .mac_data  (mac_data),
    .mac_valid (mac_valid),
    .mac_ready (mac_ready),
    .cur_id    (cur_id),
    .spk_valid (spk_valid),
    .spk_id    (spk_id),
    .busy      (busy),
    .step_done (step_done),
    .dbg_idx   (dbg_idx),
    .dbg_v     (dbg_v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int cyc; } ev_t;
  ev_t spk_q[$];
  int  done_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every spike or step_done must match the head of its queue, in id and cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (spk_valid) begin
        $display("spike    id=%0d cycle=%0d", spk_id, cyc);
        if (spk_q.size() == 0) begin
          chk("unexpected_spike", 1, 0);
        end else begin
          ev_t e;
          e = spk_q.pop_front();
          chk("spk_id", int'(spk_id), e.id);
          chk("spk_cycle", cyc, e.cyc);
        end
      end
      if (step_done) begin
        $display("done     cycle=%0d", cyc);
        if (done_q.size() == 0) begin
          chk("unexpected_step_done", 1, 0);
        end else begin
          chk("step_done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  task automatic check_mem(input int e0, input int e1, input int e2, input int e3);
    int ex [4];
    ex = '{e0, e1, e2, e3};
    for (int k = 0; k < N; k++) begin
      dbg_idx = 2'(k);
      #1;
      $display("membrane idx=%0d v=%0d", k, $signed(dbg_v));
      chk($sformatf("dbg_v[%0d]", k), int'($signed(dbg_v)), ex[k]);
    end
  endtask

  // d holds per-neuron input (index 3 first); mask marks neurons expected to fire.
  task automatic run_step(input logic [3:0][7:0] d, input logic [3:0] mask,
                          input int stall1, input int stray_at, input int rst_at);
    int c0;
    int stall_left;
    int exp_idle;
    bit ended;
    @(posedge clk);
    #1;
    step_start = 1'b1;
    mac_valid  = 1'b1;
    c0 = cyc;
    $display("step     start cycle=%0d", c0);
    for (int k = 0; k < N; k++) begin
      if (mask[k]) spk_q.push_back('{k, c0 + 2 + 2 * k + ((k >= 1) ? stall1 : 0)});
    end
    if (rst_at < 0) done_q.push_back(c0 + 2 * N + 1 + stall1);
    chk("busy_cycle0", int'(busy), 0);
    stall_left = stall1;
    exp_idle = (rst_at >= 0) ? rst_at + 1 : 2 * N + 2 + stall1;
    ended = 1'b0;
    for (int i = 1; i < 60; i++) begin
      @(posedge clk);
      #1;
      step_start = (i == stray_at);
      if (rst_at >= 0 && i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst = 1'b0;
        chk("busy_after_rst", int'(busy), 0);
        chk("mac_ready_after_rst", int'(mac_ready), 0);
      end
      if (i == 1) chk("busy_cycle1", int'(busy), 1);
      mac_data = d[cur_id];
      if (mac_ready && cur_id == 2'd1 && stall_left > 0) begin
        mac_valid = 1'b0;
        stall_left--;
      end else begin
        mac_valid = 1'b1;
      end
      if (!busy && i >= 2) begin
        chk("idle_cycle", i, exp_idle);
        ended = 1'b1;
        break;
      end
    end
    if (!ended) begin
      n_cmp++;
      n_bad++;
      $display("FAIL step_timeout: busy still 1, expected idle by cycle %0d", exp_idle);
    end
    step_start = 1'b0;
    mac_valid  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mac_ready", int'(mac_ready), 0);
    chk("rst_spk_valid", int'(spk_valid), 0);
    chk("rst_spk_id", int'(spk_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step_done", int'(step_done), 0);
    check_mem(0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef NCHU_REFRACT_EN
    run_step({8'd5, 8'd0, 8'd0, 8'd0}, 4'b1000, 0, -1, -1);
    check_mem(0, 0, 0, 3);
    run_step({8'd5, 8'd0, 8'd0, 8'd0}, 4'b0000, 0, -1, -1);
    check_mem(0, 0, 0, 0);
    run_step({8'd5, 8'd0, 8'd0, 8'd0}, 4'b0000, 0, -1, -1);
    check_mem(0, 0, 0, 0);
    run_step({8'd5, 8'd0, 8'd0, 8'd0}, 4'b1000, 0, -1, -1);
    check_mem(0, 0, 0, 3);
`else
    run_step({8'd5, 8'd2, 8'd1, 8'd0}, 4'b1100, 0, -1, -1);
    check_mem(0, 1, 0, 3);
    run_step({8'd5, 8'd2, 8'd1, 8'd0}, 4'b1100, 0, -1, -1);
    check_mem(0, 1, 0, 4);
    run_step({8'd5, 8'd2, 8'd1, 8'd0}, 4'b0000, 0, -1, 4);
    repeat (6) @(posedge clk);
    #1;
    check_mem(0, 0, 0, 0);
    run_step({8'd0, 8'd0, 8'h80, 8'd127}, 4'b0001, 0, -1, -1);
    check_mem(125, -128, 0, 0);
    run_step({8'd0, 8'd0, 8'h80, 8'd127}, 4'b0001, 0, -1, -1);
    check_mem(125, -128, 0, 0);
    run_step({8'd5, 8'd2, 8'd1, 8'd0}, 4'b1101, 3, 5, -1);
    check_mem(91, -95, 0, 3);
`endif

    repeat (8) @(posedge clk);
    #1;
    chk("spikes_left", spk_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nchu_scheduler.md
# nchu_scheduler

Time-multiplexing controller for the NCHU leaky integrate-and-fire core. One physical integrate/leak/fire datapath serves `N_NEURONS` virtual neurons, with membrane potentials held in an internal register file. On each timestep the block walks the neurons in index order. For each neuron it accepts one synaptic current from the MAC stage, then applies leak, integrate and fire. It sits between the MAC array (upstream) and the spike router (downstream).

## Interface
- `N_NEURONS`, 8: virtual neurons per core (2..64).
- `THRESH`, 8'sd2: firing threshold, signed, 1..127.
- `REFRACT_STEPS`, 2: refractory length in timesteps (used only with `NCHU_REFRACT_EN`, 1..15).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `step_start` in 1: begin a timestep; sampled only in IDLE.
- `mac_data` in 8: signed synaptic current for neuron `cur_id`.
- `mac_valid` in 1: `mac_data` is valid.
- `mac_ready` out 1: block accepts `mac_data` this cycle.
- `cur_id` out clog2(N) bits: neuron currently being served.
- `spk_valid` out 1: neuron `spk_id` fires this cycle.
- `spk_id` out clog2(N) bits: index of the firing neuron.
- `busy` out 1: a timestep is in progress.
- `step_done` out 1: single-cycle pulse at the end of a timestep.
- `dbg_idx` in clog2(N) bits: debug read address.
- `dbg_v` out 8: combinational read of membrane[`dbg_idx`].

## Operation
- **States:** IDLE, ACCEPT, CHECK, DONE.
- **IDLE:**
  - If `step_start`=1, go to ACCEPT and set `idx`=0.
  - `step_start` in any other state is ignored.
- **ACCEPT:**
  - `mac_ready`=1.
  - On `mac_valid`&`mac_ready`: `v_tmp` = sat8((v>>>1) + (v>>>2) + `mac_data`), with v = membrane[`idx`]. Then go to CHECK.
  - Otherwise remain in ACCEPT.
- **Arithmetic:**
  - Arithmetic shifts on signed 8-bit values.
  - The sum is formed at 10 bits, then saturated to [-128, 127].
- **CHECK:**
  - fire = (`v_tmp` >= `THRESH`), signed compare.
  - `spk_valid` = fire and `spk_id` = `idx`.
  - Write membrane[`idx`] = fire ? `v_tmp` − `THRESH` : `v_tmp`. No underflow is possible.
  - If `idx` = N−1, go to DONE. Otherwise increment `idx` and go to ACCEPT.
- **DONE:** `step_done`=1, then go to IDLE.
- **Outputs:**
  - `busy` = (state ≠ IDLE).
  - `cur_id` = `idx`.
  - `mac_ready` = (state = ACCEPT).
- **Reset:**
  - All membranes are 0, state is IDLE, `idx`=0.
  - `mac_ready`, `spk_valid`, `spk_id`, `busy`, `step_done` are all 0.
- **rst mid-step:** the step is abandoned with no `step_done` and no further spikes. Membranes are cleared.
- **Debug port:** `dbg_v` reflects writes from the cycle after a CHECK.

## Timing
- Denote by cycle 0 the cycle in which `step_start` is high while in IDLE.
- With `mac_valid` held high, neuron k is in ACCEPT in cycle 1+2k and in CHECK in cycle 2+2k.
- DONE occurs in cycle 2N+1, and the block is back in IDLE in cycle 2N+2.
- `busy` is high in cycles 1..2N+1.
- Each cycle of `mac_valid`=0 in ACCEPT delays every later event by one cycle.
- `step_start` may be reasserted in the cycle after DONE. Back-to-back steps therefore cost 2N+2 cycles each.
- `spk_valid` is high at most once per neuron per step and is never high outside CHECK.

## Configuration
- **`NCHU_REFRACT_EN` defined:**
  - Adds a 4-bit refractory counter per neuron, reset to 0.
  - On fire, the neuron's counter loads `REFRACT_STEPS`.
  - In CHECK, if the counter is nonzero on entry:
    - the input is still consumed through the handshake;
    - membrane is forced to 0;
    - fire is suppressed;
    - the counter is decremented.
  - The counter is cleared by `rst`.
- **`NCHU_REFRACT_EN` undefined:**
  - No counters exist and `REFRACT_STEPS` is unused.
  - Behaviour is exactly as described above.

## Test plan
All scenarios use N=4 and THRESH=2 unless noted.
- **Reset:** assert `rst` for 2 cycles, then `step_start` → all outputs are 0 during reset and `dbg_v`=0 for all indices. `busy` rises in the cycle after `step_start`.
- **Single step:** `mac_data`=0,1,2,5 with `mac_valid` held high → spikes with `spk_id`=2 in cycle 6 and `spk_id`=3 in cycle 8; `step_done` in cycle 9. Membranes afterwards are 0,1,0,3.
- **Second step, same inputs:** neuron3 gives 1+5=6, fires, membrane 4. Neuron1 gives 0+1=1, no spike. Neuron2 fires again with membrane 0.
- **Saturation:** membrane 127 with input 127 → `v_tmp`=127, fires, membrane 125. Membrane −128 with input −128 → −128, no spike.
- **Backpressure and stray start:** hold `mac_valid` low for 3 cycles at neuron1 → `step_done` moves from cycle 9 to 12. `step_start` pulsed while busy is ignored, and exactly one `step_done` is produced.
- **Reset mid-step:** `rst` asserted in cycle 4 → IDLE next cycle, no `step_done`, all membranes 0.
- **Refractory (with `NCHU_REFRACT_EN`, REFRACT_STEPS=2):** neuron3 receives input 5 for 4 steps → fires in steps 1 and 4 only, with membrane 0 after steps 2 and 3.
